// File: rtl/bitboard_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bitboard_serializer
// Description : Walks a 64-bit bitboard and emits the index of each set bit,
//               lowest first, one square per accepted handshake. Each bitboard
//               ends with a single-cycle done pulse.
// Option      : BITBOARD_SERIALIZER_REMAINING_EN adds the 'remaining' output,
//               which counts the squares not yet accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module bitboard_serializer (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bb_in,
  input  logic        bb_valid,
  output logic        bb_ready,
  output logic [5:0]  square,
  output logic        square_valid,
  input  logic        square_ready,
  output logic        square_last,
  output logic        done,
  input  logic        flush
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
  ,
  output logic [6:0]  remaining
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] bb_q, bb_d;
  logic [5:0]  square_q, square_d;
  logic        last_q, last_d;
  logic        done_q, done_d;

  // Index of the lowest set bit. An empty board gives 0, but that value is
  // never shown because empty boards skip the EMIT state.
  function automatic logic [5:0] ls1b(input logic [63:0] b);
    logic [5:0] idx;
    idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (b[i]) idx = 6'(i);
    end
    return idx;
  endfunction

  // A board has exactly one set bit when it is non-zero and clearing its
  // lowest set bit leaves nothing. The caller guarantees b is non-zero.
  function automatic logic single_bit(input logic [63:0] b);
    return (b & (b - 64'd1)) == 64'd0;
  endfunction

  // Board after the current square is retired.
  logic [63:0] w_cleared;
  assign w_cleared = bb_q & (bb_q - 64'd1);

`ifdef BITBOARD_SERIALIZER_REMAINING_EN
  logic [6:0] rem_q, rem_d;

  function automatic logic [6:0] popcount(input logic [63:0] b);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + 7'(b[i]);
    end
    return c;
  endfunction
`endif

  // Next-state logic. A flush wins over both a load and a square handshake.
  always_comb begin
    state_d  = state_q;
    bb_d     = bb_q;
    square_d = square_q;
    last_d   = last_q;
    done_d   = 1'b0;
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
    rem_d    = rem_q;
`endif
    if (flush) begin
      state_d  = ST_IDLE;
      bb_d     = '0;
      square_d = '0;
      last_d   = 1'b0;
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
      rem_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bb_valid) begin
            if (bb_in == 64'd0) begin
              done_d = 1'b1;
            end else begin
              state_d  = ST_EMIT;
              bb_d     = bb_in;
              square_d = ls1b(bb_in);
              last_d   = single_bit(bb_in);
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
              rem_d    = popcount(bb_in);
`endif
            end
          end
        end
        ST_EMIT: begin
          if (square_ready) begin
            if (last_q) begin
              state_d  = ST_IDLE;
              done_d   = 1'b1;
              bb_d     = '0;
              square_d = '0;
              last_d   = 1'b0;
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
              rem_d    = '0;
`endif
            end else begin
              bb_d     = w_cleared;
              square_d = ls1b(w_cleared);
              last_d   = single_bit(w_cleared);
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
              rem_d    = rem_q - 7'd1;
`endif
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers. Reset acts immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bb_q     <= '0;
      square_q <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bb_q     <= bb_d;
      square_q <= square_d;
      last_q   <= last_d;
      done_q   <= done_d;
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
      rem_q    <= rem_d;
`endif
    end
  end

  assign bb_ready     = (state_q == ST_IDLE);
  assign square_valid = (state_q == ST_EMIT);
  assign square       = square_q;
  assign square_last  = last_q;
  assign done         = done_q;
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
  assign remaining    = rem_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitboard_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitboard_serializer
// Description : Self-checking bench for bitboard_serializer. Uses a table of
//               bitboards with hand-computed count, first and last squares,
//               plus directed sequences for stalls, flush, reset and
//               back-to-back loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitboard_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] bb_in;
  logic        bb_valid;
  logic        bb_ready;
  logic [5:0]  square;
  logic        square_valid;
  logic        square_ready;
  logic        square_last;
  logic        done;
  logic        flush;
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
  logic [6:0]  remaining;
`endif

  int checks = 0;
  int errors = 0;

  bitboard_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .bb_in        (bb_in),
    .bb_valid     (bb_valid),
    .bb_ready     (bb_ready),
    .square       (square),
    .square_valid (square_valid),
    .square_ready (square_ready),
    .square_last  (square_last),
    .done         (done),
    .flush        (flush)
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
    ,
    .remaining    (remaining)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bb;
    int          n;
    int          first;
    int          lastsq;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Index of the k-th set bit (counting from 0) found by scanning upward.
  function automatic int nth_set(input logic [63:0] b, input int k);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) begin
        if (cnt == k) return i;
        cnt++;
      end
    end
    return -1;
  endfunction

  task automatic run_vec(input vec_t v);
    int k;
    int cyc;
    logic [5:0] first_seen;
    logic [5:0] last_seen;
    first_seen = '0;
    last_seen  = '0;
    chk("load_ready", bb_ready, 1);
    bb_in = v.bb; bb_valid = 1'b1; square_ready = 1'b1;
    tick();
    bb_valid = 1'b0; bb_in = '0;
    if (v.n == 0) begin
      chk("empty_done", done, 1);
      chk("empty_valid", square_valid, 0);
      chk("empty_ready", bb_ready, 1);
      tick();
      chk("empty_done_pulse", done, 0);
    end else begin
      k = 0; cyc = 0;
      while (k < v.n && cyc < 200) begin
        if (square_valid) begin
          chk("sq", square, nth_set(v.bb, k));
          chk("sq_last", square_last, (k == v.n - 1));
          chk("done_low", done, 0);
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
          chk("remaining", remaining, v.n - k);
`endif
          if (k == 0) first_seen = square;
          last_seen = square;
          k++;
        end
        cyc++;
        tick();
      end
      chk("count", k, v.n);
      chk("throughput", cyc, v.n);
      chk("first_sq", first_seen, v.first);
      chk("last_sq", last_seen, v.lastsq);
      chk("fin_done", done, 1);
      chk("fin_valid", square_valid, 0);
      chk("fin_ready", bb_ready, 1);
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
      chk("fin_remaining", remaining, 0);
`endif
      tick();
      chk("fin_done_pulse", done, 0);
    end
  endtask

  initial begin
    int k;
    int cyc;
    int exp_sq[2];

    vecs[0] = '{64'h0000_0000_0000_0081, 2, 0, 7};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 63};
    vecs[2] = '{64'h0000_0000_0000_0000, 0, 0, 0};
    vecs[3] = '{64'h8000_0000_0000_0010, 2, 4, 63};
    vecs[4] = '{64'h0000_0000_0000_0001, 1, 0, 0};
    vecs[5] = '{64'h8000_0000_0000_0000, 1, 63, 63};
    vecs[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 32, 1, 63};
    vecs[7] = '{64'h0000_0100_0000_F000, 5, 12, 40};

    reset = 1'b1; bb_in = '0; bb_valid = 1'b0; square_ready = 1'b0; flush = 1'b0;
    #2;
    chk("rst_ready", bb_ready, 1);
    chk("rst_valid", square_valid, 0);
    chk("rst_square", square, 0);
    chk("rst_last", square_last, 0);
    chk("rst_done", done, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Random back-pressure: each square must be held until accepted.
    exp_sq[0] = 4; exp_sq[1] = 63;
    bb_in = 64'h8000_0000_0000_0010; bb_valid = 1'b1; square_ready = 1'b0;
    tick();
    bb_valid = 1'b0;
    k = 0; cyc = 0;
    while (k < 2 && cyc < 200) begin
      if (square_valid) begin
        chk("rr_sq", square, exp_sq[k]);
        chk("rr_last", square_last, (k == 1));
      end
      square_ready = 1'($urandom_range(0, 1));
      if (square_valid && square_ready) k++;
      cyc++;
      tick();
    end
    chk("rr_count", k, 2);
    chk("rr_done", done, 1);
    chk("rr_idle", bb_ready, 1);
    square_ready = 1'b1;
    tick();

    // Flush after square 8 is accepted; a same-cycle handshake on 9 is dropped.
    bb_in = 64'h0F00; bb_valid = 1'b1;
    tick();
    bb_valid = 1'b0;
    chk("fl_sq8", square, 8);
    tick();
    chk("fl_sq9", square, 9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", square_valid, 0);
    chk("fl_ready", bb_ready, 1);
    chk("fl_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_quiet", square_valid, 0);
    end
    run_vec('{64'h2, 1, 1, 1});

    // Flush beats a load in IDLE.
    flush = 1'b1; bb_valid = 1'b1; bb_in = 64'h5;
    tick();
    flush = 1'b0; bb_valid = 1'b0;
    chk("flld_valid", square_valid, 0);
    chk("flld_ready", bb_ready, 1);
    chk("flld_done", done, 0);

    // Empty load followed immediately by a real load, then a load in the done cycle.
    bb_in = '0; bb_valid = 1'b1;
    tick();
    chk("b2b_done", done, 1);
    chk("b2b_ready", bb_ready, 1);
    bb_in = 64'h81;
    tick();
    bb_valid = 1'b0;
    chk("b2b_valid", square_valid, 1);
    chk("b2b_sq0", square, 0);
    chk("b2b_done_low", done, 0);
    tick();
    chk("b2b_sq7", square, 7);
    chk("b2b_last", square_last, 1);
    tick();
    chk("b2b_done2", done, 1);
    chk("b2b_ready2", bb_ready, 1);
    bb_in = 64'h1; bb_valid = 1'b1;
    tick();
    bb_valid = 1'b0;
    chk("b2b_reload_valid", square_valid, 1);
    chk("b2b_reload_sq", square, 0);
    chk("b2b_reload_last", square_last, 1);
    tick();
    chk("b2b_reload_done", done, 1);

    // Asynchronous reset in the middle of 0xFF.
    bb_in = 64'hFF; bb_valid = 1'b1;
    tick();
    bb_valid = 1'b0;
    tick();
    chk("mr_sq1", square, 1);
    reset = 1'b1;
    #1;
    chk("mr_valid", square_valid, 0);
    chk("mr_ready", bb_ready, 1);
    chk("mr_square", square, 0);
    chk("mr_last", square_last, 0);
    chk("mr_done", done, 0);
`ifdef BITBOARD_SERIALIZER_REMAINING_EN
    chk("mr_remaining", remaining, 0);
`endif
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_quiet", square_valid, 0);
      chk("mr_idle", bb_ready, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
